// File: rtl/keypad_pkg.sv
// Shared types, keymap and default timing for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam int SCAN_DIV_DEFAULT        = 1200;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 240000;

  // Indexed by {row, col}; entry 15 is r3c3.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [3:0] rows);
    logic [3:0] low;
    low = ~rows;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync
  import keypad_pkg::*;
(
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce.
// KEYPAD_MULTIKEY_REJECT_EN: ignore scan samples with more than one row low.
//
// state     | meaning
// SCAN      | rotating column drive, sampling rows at end of each column period
// DEB_PRESS | column frozen, rows must match captured pattern to accept
// HELD      | key accepted, bstate high, waiting for all rows high
// DEB_REL   | rows high, must stay high to release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] button,
  output logic       bstate,
  output logic       key_valid
);

  localparam int DIVW = $clog2(SCAN_DIV + 1);
  localparam int DEBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(SCAN_DIV - 1);
  localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBW-1:0] DEB_MAX  = DEBW'(DEBOUNCE_CYCLES);

  state_t          state;
  logic [3:0]      row_s;
  logic [1:0]      col_idx;
  logic [DIVW-1:0] div_cnt;
  logic [DEBW-1:0] deb_cnt;
  logic [3:0]      cap_rows;
  logic [1:0]      cap_row_idx;
  logic            sample_hit;

  row_sync u_row_sync (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (row_s)
  );

  always_comb begin
    sample_hit = (row_s != 4'hF);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    if (multi_low(row_s)) sample_hit = 1'b0;
`endif
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      col_out     <= 4'b1110;
      div_cnt     <= DIV_LOAD;
      deb_cnt     <= '0;
      cap_rows    <= 4'hF;
      cap_row_idx <= 2'd0;
      button      <= 4'h0;
      bstate      <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (sample_hit) begin
            cap_rows    <= row_s;
            cap_row_idx <= low_row_idx(row_s);
            deb_cnt     <= '0;
            state       <= DEB_PRESS;
          end else begin
            col_idx <= col_idx + 2'd1;
            col_out <= col_drive(col_idx + 2'd1);
            div_cnt <= DIV_LOAD;
          end
        end
        DEB_PRESS: begin
          // Bounce aborts back to scanning the same column.
          if (row_s != cap_rows) begin
            state   <= SCAN;
            div_cnt <= DIV_LOAD;
          end else begin
            if (deb_cnt == DEB_LAST) begin
              button    <= KEYMAP[{cap_row_idx, col_idx}];
              key_valid <= 1'b1;
              state     <= HELD;
            end
            if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          bstate <= 1'b1;
          if (row_s == 4'hF) begin
            deb_cnt <= '0;
            state   <= DEB_REL;
          end
        end
        DEB_REL: begin
          if (row_s != 4'hF) begin
            state <= HELD;
          end else begin
            if (deb_cnt == DEB_LAST) begin
              bstate  <= 1'b0;
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
              col_out <= col_drive(col_idx + 2'd1);
              div_cnt <= DIV_LOAD;
            end
            if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic        hwclk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  button;
  logic        bstate;
  logic        key_valid;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int kv_count = 0;
  int rises = 0;
  int falls = 0;
  int n_accept = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_button = 4'h0;

  typedef struct {
    int         r;
    int         c;
    int         hold;
    bit         accept;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 hwclk = ~hwclk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .button    (button),
    .bstate    (bstate),
    .key_valid (key_valid)
  );

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard and temporal monitor.
  logic       rst_q;
  logic       prev_kv = 1'b0;
  logic       prev_bstate = 1'b0;
  logic [3:0] prev_button = 4'h0;

  always @(posedge hwclk) rst_q <= rst_n;

  always @(negedge hwclk) begin
    if (rst_q === 1'b1) begin
      if (key_valid) begin
        kv_count++;
        check("kv_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("kv_button", button, exp_q.pop_front());
        check("bstate_low_at_kv", bstate, 0);
      end else begin
        check("button_stable", button, prev_button);
      end
      if (prev_kv) begin
        check("bstate_rise_latency", bstate, 1);
        check("kv_single_cycle", key_valid, 0);
      end
    end
    if (!prev_bstate && bstate === 1'b1) rises++;
    if (prev_bstate && bstate === 1'b0) falls++;
    prev_kv     = (key_valid === 1'b1);
    prev_bstate = (bstate === 1'b1);
    prev_button = button;
  end

  task automatic align_col(input int col);
    int n;
    n = 0;
    while (col_out[col] == 1'b0 && n < 64) begin @(negedge hwclk); n++; end
    while (col_out[col] == 1'b1 && n < 64) begin @(negedge hwclk); n++; end
    check("align_timeout", n < 64, 1);
  endtask

  task automatic wait_fall(output int cyc);
    cyc = 0;
    while (bstate == 1'b1 && cyc < 100) begin @(negedge hwclk); cyc++; end
    check("fall_timeout", cyc < 100, 1);
  endtask

  task automatic expect_key(input logic [3:0] b);
    exp_q.push_back(b);
    n_accept++;
    last_button = b;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int falls0;

    vecs[0] = '{1, 1, 20, 1'b1, 4'h5};
    vecs[1] = '{2, 0,  3, 1'b0, 4'h0};
    vecs[2] = '{0, 3, 20, 1'b1, 4'hA};
    vecs[3] = '{3, 0, 20, 1'b1, 4'hE};
    vecs[4] = '{3, 3, 20, 1'b1, 4'hD};
    vecs[5] = '{2, 1, 20, 1'b1, 4'h8};

    rst_n = 1'b0;
    repeat (3) @(negedge hwclk);
    check("rst_col_out", col_out, 4'hE);
    check("rst_button", button, 0);
    check("rst_bstate", bstate, 0);
    check("rst_key_valid", key_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge hwclk);

    for (int i = 0; i < 6; i++) begin
      align_col(vecs[i].c);
      if (vecs[i].accept) expect_key(vecs[i].exp);
      keys = 16'b1 << (vecs[i].r * 4 + vecs[i].c);
      repeat (vecs[i].hold) @(negedge hwclk);
      keys = '0;
      wait_fall(cyc);
      if (vecs[i].accept) check("release_delay", (cyc >= DEB) && (cyc <= DEB + 6), 1);
      repeat (20) @(negedge hwclk);
      check("vec_button", button, last_button);
      check("vec_kv_count", kv_count, n_accept);
      check("vec_bstate_idle", bstate, 0);
    end

    // Release bounce: high / low / high must give one falling edge.
    align_col(1);
    expect_key(4'h0);
    keys = 16'b1 << 13;
    repeat (20) @(negedge hwclk);
    check("bounce_held", bstate, 1);
    falls0 = falls;
    keys = '0;
    @(negedge hwclk);
    keys = 16'b1 << 13;
    @(negedge hwclk);
    keys = '0;
    wait_fall(cyc);
    repeat (20) @(negedge hwclk);
    check("bounce_single_fall", falls - falls0, 1);
    check("bounce_button", button, 0);
    check("bounce_kv_count", kv_count, n_accept);

    // Two rows low in the same column.
    align_col(0);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    keys = (16'b1 << 0) | (16'b1 << 4);
    repeat (40) @(negedge hwclk);
    check("multikey_no_bstate", bstate, 0);
`else
    expect_key(4'h1);
    keys = (16'b1 << 0) | (16'b1 << 4);
    repeat (20) @(negedge hwclk);
    check("multikey_held", bstate, 1);
`endif
    keys = '0;
    wait_fall(cyc);
    repeat (20) @(negedge hwclk);
    check("multikey_button", button, last_button);
    check("multikey_kv_count", kv_count, n_accept);

    // Second key in the same row while the first is held.
    align_col(1);
    expect_key(4'h2);
    keys = 16'b1 << 1;
    repeat (16) @(negedge hwclk);
    keys = keys | (16'b1 << 2);
    repeat (12) @(negedge hwclk);
    check("second_key_button", button, 2);
    keys = '0;
    wait_fall(cyc);
    repeat (20) @(negedge hwclk);
    check("second_key_kv_count", kv_count, n_accept);
    check("second_key_button_after", button, 2);

    // Reset while held.
    align_col(2);
    expect_key(4'h9);
    keys = 16'b1 << 10;
    repeat (20) @(negedge hwclk);
    check("pre_reset_bstate", bstate, 1);
    check("pre_reset_button", button, 9);
    rst_n = 1'b0;
    keys = '0;
    @(negedge hwclk);
    check("held_rst_bstate", bstate, 0);
    check("held_rst_button", button, 0);
    check("held_rst_col_out", col_out, 4'hE);
    check("held_rst_key_valid", key_valid, 0);
    rst_n = 1'b1;
    last_button = 4'h0;
    repeat (30) @(negedge hwclk);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_kv_count", kv_count, n_accept);
    check("final_rises", rises, n_accept);
    check("final_falls", falls, n_accept);
    check("final_button", button, last_button);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1200; hwclk cycles per column step.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 240000; hwclk cycles of stable input required (20 ms at 12 MHz).
REQ-003 SHALL have port hwclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous.
REQ-006 SHALL have port col_out  output  4  column drive, one-cold (exactly one bit 0).
REQ-007 SHALL have port button  output  4  code of the last accepted key.
REQ-008 SHALL have port bstate  output  1  high while the accepted key is held; consumers act on its falling edge.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on press acceptance.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all row references below mean the synchronized value (2-cycle latency).
REQ-011 SHALL use FSM states SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-012 SCAN: col_out SHALL rotate 1110->1101->1011->0111->1110, one step per SCAN_DIV cycles; rows SHALL be sampled on the last cycle of each column period.
REQ-013 SCAN: a sample with any row low SHALL freeze the column, capture the row pattern, clear the debounce counter, and enter DEB_PRESS.
REQ-014 DEB_PRESS: rows SHALL equal the captured pattern for DEBOUNCE_CYCLES consecutive cycles to accept; any mismatch SHALL return to SCAN with no output change.
REQ-015 On acceptance, button SHALL be loaded from the keymap in the same cycle key_valid pulses; bstate SHALL rise one cycle later; state becomes HELD.
REQ-016 Keymap (row,col): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-017 HELD: rows all high SHALL enter DEB_REL; other row changes (second key) SHALL be ignored.
REQ-018 DEB_REL: rows all high for DEBOUNCE_CYCLES consecutive cycles SHALL clear bstate and resume SCAN at the next column; any low row SHALL return to HELD with no bstate edge.
REQ-019 button SHALL remain stable from acceptance until the next acceptance, including through and after the bstate falling edge.
REQ-020 bstate SHALL produce exactly one rise and one fall per accepted keystroke regardless of bounce.
REQ-021 Debounce counter SHALL saturate at DEBOUNCE_CYCLES and never wrap.
REQ-022 key_valid SHALL never assert in any state other than the DEB_PRESS->HELD transition.

Reset
REQ-023 While rst_n=0 at a clock edge: state SCAN, col_out=1110, button=0, bstate=0, key_valid=0, counters and synchronizer 0/1 (rows idle high).
REQ-024 Reset asserted in any state, including HELD, SHALL take effect on the next edge with bstate dropping to 0 without debounce.

Configuration
REQ-025 Macro KEYPAD_MULTIKEY_REJECT_EN defined: a SCAN sample with more than one row low SHALL be ignored (no DEB_PRESS entry).
REQ-026 Macro undefined: the lowest-index low row SHALL be taken; the other rows are ignored.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state typedef, the 16-entry keymap constant, and default SCAN_DIV/DEBOUNCE_CYCLES values.
REQ-028 Synchronizer SHALL be sub-module row_sync (4-bit, 2-flop, reset to 1111).

Verification (bench parameters SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-029 Clean press of r1c1 held 20 cycles, then released -> key_valid pulse, button=5, bstate rises one cycle later, falls 8+ cycles after release, button stays 5.
REQ-030 r2c0 pressed 3 cycles then released -> no key_valid, bstate stays 0, button unchanged.
REQ-031 r3c1 accepted, then release with 3-cycle bounce (high/low/high) -> single bstate fall, button=0.
REQ-032 r0c0+r1c0 pressed together -> with macro: no acceptance; without: button=1.
REQ-033 rst_n low for one cycle while HELD with button=9 -> bstate=0, button=0, col_out=1110 next cycle.
REQ-034 Second key r0c2 pressed while r0c1 held -> button remains 2, no extra key_valid.
